probador_param_gen: RTL and testbench

// Synthesizable, parametrised stimulus generator for the PHY link: drives LANES parallel

---
 rtl/probador_param_gen.sv | 169 ++++++++++++++++
 tb/tb_probador_param_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/probador_param_gen.sv
`default_nettype none
// ============================================================================
//  Module   : probador_param_gen
//  Purpose  : Parametrised PHY-link stimulus generator. Drives LANES parallel
//             WIDTH-bit lane words with valids, plus a serial stream (MSB
//             first) made of COM_COUNT sync symbols followed by round-robin
//             lane data, with IDLE_SYM in place of invalid lanes.
//  Revision : 1.0 - initial release
// ============================================================================
module probador_param_gen #(
  parameter int          LANES     = 4,
  parameter int          WIDTH     = 8,
  parameter logic [15:0] COM_SYM   = 16'h00BC,
  parameter logic [15:0] IDLE_SYM  = 16'h007C,
  parameter int          COM_COUNT = 4
) (
  input  logic                     clk_32f,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [LANES-1:0]         valid_mask,
  output logic [LANES*WIDTH-1:0]   data_out,
  output logic [LANES-1:0]         valid_out,
  output logic                     ser_out,
  output logic                     sym_strobe,
  output logic                     sync_done
);

  localparam int c_POS_W = $clog2(WIDTH);
  localparam int c_LP_W  = (LANES > 1) ? $clog2(LANES) : 1;

  // Symbols narrower than the parameter field are zero-extended on the MSB side.
  localparam logic [WIDTH-1:0]   c_COM_SYM  = COM_SYM[WIDTH-1:0];
  localparam logic [WIDTH-1:0]   c_IDLE_SYM = IDLE_SYM[WIDTH-1:0];
  localparam logic [c_POS_W-1:0] c_LAST_POS = c_POS_W'(WIDTH - 1);
  localparam logic [c_POS_W-1:0] c_PRE_LAST = c_POS_W'(WIDTH - 2);
  localparam logic [3:0]         c_COM_CNT  = 4'(COM_COUNT);
  localparam logic [c_LP_W-1:0]  c_LAST_LN  = c_LP_W'(LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                   r_state,    w_state_nxt;
  logic [c_POS_W-1:0]       r_pos,      w_pos_nxt;
  logic [3:0]               r_com_cnt,  w_com_cnt_nxt;
  logic [WIDTH-1:0]         r_data_cnt, w_data_cnt_nxt;
  logic [c_LP_W-1:0]        r_lane_ptr, w_lane_ptr_nxt;
  logic [WIDTH-1:0]         r_shift,    w_shift_nxt;
  logic [LANES*WIDTH-1:0]   r_data,     w_data_nxt;
  logic [LANES-1:0]         r_valid,    w_valid_nxt;
  logic                     r_ser,      w_ser_nxt;
  logic                     r_strobe,   w_strobe_nxt;
  logic                     r_sync,     w_sync_nxt;

  logic                     w_last;
  logic [WIDTH-1:0]         w_dcnt_inc;
  logic [LANES*WIDTH-1:0]   w_lanes;
  logic [WIDTH-1:0]         w_lane_sym;
  logic [WIDTH-1:0]         w_data_sym;

  // Next-state and next-output computation; every symbol boundary reloads
  // the shifter and emits its MSB directly so no partial symbol can occur.
  always_comb begin
    w_state_nxt    = r_state;
    w_pos_nxt      = r_pos;
    w_com_cnt_nxt  = r_com_cnt;
    w_data_cnt_nxt = r_data_cnt;
    w_lane_ptr_nxt = r_lane_ptr;
    w_shift_nxt    = r_shift;
    w_data_nxt     = r_data;
    w_valid_nxt    = r_valid;
    w_ser_nxt      = r_ser;
    w_strobe_nxt   = 1'b0;
    w_sync_nxt     = r_sync;

    w_last     = (r_pos == c_LAST_POS);
    w_dcnt_inc = r_data_cnt + 1'b1;
    w_lanes    = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lanes[i*WIDTH +: WIDTH] = w_dcnt_inc + WIDTH'(i);
    end
    w_lane_sym = w_lanes[int'(r_lane_ptr)*WIDTH +: WIDTH];
    w_data_sym = valid_mask[r_lane_ptr] ? w_lane_sym : c_IDLE_SYM;

    case (r_state)
      ST_IDLE: begin
        // Parking the bit position at the last slot makes the next edge a
        // symbol boundary, which gives the single cycle of start latency.
        if (enable) begin
          w_state_nxt = ST_SYNC;
          w_pos_nxt   = c_LAST_POS;
        end
      end
      default: begin
        if (!w_last) begin
          w_ser_nxt    = r_shift[WIDTH-1];
          w_shift_nxt  = r_shift << 1;
          w_pos_nxt    = r_pos + 1'b1;
          w_strobe_nxt = (r_pos == c_PRE_LAST);
        end else if (!enable) begin
          w_state_nxt    = ST_IDLE;
          w_pos_nxt      = '0;
          w_com_cnt_nxt  = '0;
          w_data_cnt_nxt = '0;
          w_lane_ptr_nxt = '0;
          w_shift_nxt    = '0;
          w_data_nxt     = '0;
          w_valid_nxt    = '0;
          w_ser_nxt      = 1'b0;
          w_sync_nxt     = 1'b0;
        end else if ((r_state == ST_SYNC) && (r_com_cnt != c_COM_CNT)) begin
          w_ser_nxt     = c_COM_SYM[WIDTH-1];
          w_shift_nxt   = c_COM_SYM << 1;
          w_pos_nxt     = '0;
          w_com_cnt_nxt = r_com_cnt + 1'b1;
        end else begin
          w_state_nxt    = ST_DATA;
          w_sync_nxt     = 1'b1;
          w_ser_nxt      = w_data_sym[WIDTH-1];
          w_shift_nxt    = w_data_sym << 1;
          w_pos_nxt      = '0;
          w_data_cnt_nxt = w_dcnt_inc;
          w_data_nxt     = w_lanes;
          w_valid_nxt    = valid_mask;
          w_lane_ptr_nxt = (r_lane_ptr == c_LAST_LN) ? '0 : r_lane_ptr + 1'b1;
        end
      end
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pos      <= '0;
      r_com_cnt  <= '0;
      r_data_cnt <= '0;
      r_lane_ptr <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= '0;
      r_ser      <= 1'b0;
      r_strobe   <= 1'b0;
      r_sync     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pos      <= w_pos_nxt;
      r_com_cnt  <= w_com_cnt_nxt;
      r_data_cnt <= w_data_cnt_nxt;
      r_lane_ptr <= w_lane_ptr_nxt;
      r_shift    <= w_shift_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_ser      <= w_ser_nxt;
      r_strobe   <= w_strobe_nxt;
      r_sync     <= w_sync_nxt;
    end
  end

  assign data_out   = r_data;
  assign valid_out  = r_valid;
  assign ser_out    = r_ser;
  assign sym_strobe = r_strobe;
  assign sync_done  = r_sync;

endmodule
`default_nettype wire

// File: tb/tb_probador_param_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_probador_param_gen
//  Purpose  : Self-checking bench for probador_param_gen (default build and a
//             LANES=2 / WIDTH=4 build) using an expected-item scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_probador_param_gen;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [3:0]  valid_mask;
  logic [31:0] data_out;
  logic [3:0]  valid_out;
  logic        ser_out, sym_strobe, sync_done;

  logic        p_reset, p_enable;
  logic [1:0]  p_valid_mask;
  logic [7:0]  p_data_out;
  logic [1:0]  p_valid_out;
  logic        p_ser_out, p_sym_strobe, p_sync_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          ser;
    bit          stb;
    bit          sync;
    bit          wchk;
    logic [31:0] data;
    logic [3:0]  valid;
  } exp_t;

  exp_t q[$];

  // Free-running clock shared by both builds.
  always #5 clk = ~clk;

  probador_param_gen u_dut (
    .clk_32f    (clk),
    .reset      (reset),
    .enable     (enable),
    .valid_mask (valid_mask),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ser_out    (ser_out),
    .sym_strobe (sym_strobe),
    .sync_done  (sync_done)
  );

  probador_param_gen #(
    .LANES   (2),
    .WIDTH   (4),
    .COM_SYM (16'h000B)
  ) u_dut_p (
    .clk_32f    (clk),
    .reset      (p_reset),
    .enable     (p_enable),
    .valid_mask (p_valid_mask),
    .data_out   (p_data_out),
    .valid_out  (p_valid_out),
    .ser_out    (p_ser_out),
    .sym_strobe (p_sym_strobe),
    .sync_done  (p_sync_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_zero(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.ser = 1'b0; e.stb = 1'b0; e.sync = 1'b0; e.wchk = 1'b1;
      e.data = '0;  e.valid = '0;
      q.push_back(e);
    end
  endtask

  task automatic push_com(input int w, input logic [15:0] com);
    exp_t e;
    for (int b = 0; b < w; b++) begin
      e.ser = com[w-1-b]; e.stb = (b == w-1); e.sync = 1'b0; e.wchk = (b == 0);
      e.data = '0; e.valid = '0;
      q.push_back(e);
    end
  endtask

  // Reference model of one DATA symbol j (1-based since the last resync).
  task automatic push_data(input int w, input int lanes, input int j,
                           input logic [3:0] mask, input logic [15:0] idle);
    exp_t        e;
    int          mw;
    int          ptr;
    logic [31:0] d;
    logic [15:0] sym;
    mw  = (1 << w) - 1;
    ptr = (j - 1) % lanes;
    d   = '0;
    for (int i = 0; i < lanes; i++) d = d | (32'((j + i) & mw) << (i * w));
    sym = mask[ptr] ? 16'((j + ptr) & mw) : (idle & 16'(mw));
    for (int b = 0; b < w; b++) begin
      e.ser = sym[w-1-b]; e.stb = (b == w-1); e.sync = 1'b1; e.wchk = (b == 0);
      e.data = d; e.valid = mask & 4'((1 << lanes) - 1);
      q.push_back(e);
    end
  endtask

  // Pop one expected item per cycle and compare it with the selected build.
  task automatic run(input int sel, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_empty observed=0 expected=%0d", n - k);
      end else begin
        e = q.pop_front();
        if (sel == 0) begin
          check("ser_out",    32'(ser_out),    32'(e.ser));
          check("sym_strobe", 32'(sym_strobe), 32'(e.stb));
          check("sync_done",  32'(sync_done),  32'(e.sync));
          if (e.wchk) begin
            check("data_out",  data_out,         e.data);
            check("valid_out", 32'(valid_out),   32'(e.valid));
          end
        end else begin
          check("p_ser_out",    32'(p_ser_out),    32'(e.ser));
          check("p_sym_strobe", 32'(p_sym_strobe), 32'(e.stb));
          check("p_sync_done",  32'(p_sync_done),  32'(e.sync));
          if (e.wchk) begin
            check("p_data_out",  32'(p_data_out),  e.data);
            check("p_valid_out", 32'(p_valid_out), 32'(e.valid));
          end
        end
      end
    end
  endtask

  task automatic check_main_zero(input string tag);
    check({tag, "_data"},   data_out,        32'h0);
    check({tag, "_valid"},  32'(valid_out),  32'h0);
    check({tag, "_ser"},    32'(ser_out),    32'h0);
    check({tag, "_strobe"}, 32'(sym_strobe), 32'h0);
    check({tag, "_sync"},   32'(sync_done),  32'h0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; valid_mask = 4'hF;
    p_reset = 1'b0; p_enable = 1'b1; p_valid_mask = 2'b11;

    // Reset held with enable high: everything stays zero.
    repeat (3) @(negedge clk);
    check_main_zero("reset");
    check("reset_p_data", 32'(p_data_out), 32'h0);
    check("reset_p_ser",  32'(p_ser_out),  32'h0);

    // Release: one idle-looking cycle, 4 COMs, then data with all lanes valid.
    reset = 1'b1;
    push_zero(1);
    for (int s = 0; s < 4; s++) push_com(8, 16'h00BC);
    for (int j = 1; j <= 4; j++) push_data(8, 4, j, 4'hF, 16'h007C);
    run(0, 1 + 32 + 28);

    // Mask change in the middle of symbol 4 only takes effect at symbol 5.
    valid_mask = 4'b1101;
    for (int j = 5; j <= 9; j++) push_data(8, 4, j, 4'b1101, 16'h007C);
    run(0, 4 + 32 + 4);

    // Drop enable at bit 3 of symbol 9: it still completes, then IDLE.
    enable = 1'b0;
    push_zero(6);
    run(0, 4 + 6);

    // Re-enable: full resync and data counter restarts from 1.
    enable = 1'b1;
    push_zero(1);
    for (int s = 0; s < 4; s++) push_com(8, 16'h00BC);
    push_data(8, 4, 1, 4'b1101, 16'h007C);
    push_data(8, 4, 2, 4'b1101, 16'h007C);
    run(0, 1 + 32 + 8 + 5);

    // Asynchronous reset while bit 5 of a symbol is on the line.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_main_zero("async_rst");
    q.delete();

    // Narrow build: COM 1011 x4, then data with data_cnt wrapping F -> 0.
    @(negedge clk);
    p_reset = 1'b1;
    push_zero(1);
    for (int s = 0; s < 4; s++) push_com(4, 16'h000B);
    for (int j = 1; j <= 16; j++) push_data(4, 2, j, 4'b0011, 16'h007C);
    run(1, 1 + 16 + 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
